// File: rtl/dff_rr_write_arbiter_if.sv
// Bundle between N write requesters and the shared-register arbiter.
// The master side is the requester population; the slave side is the arbiter.
interface dff_rr_write_arbiter_if #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 8
);
  localparam int unsigned IW = $clog2(N);

  logic [N-1:0]   req;
  logic [N*W-1:0] wdata;
  logic [N-1:0]   gnt;
  logic [N-1:0]   ack;
  logic [W-1:0]   q;
  logic [IW-1:0]  owner;
  logic           busy;

  modport master (
    output req, wdata,
    input  gnt, ack, q, owner, busy
  );

  modport slave (
    input  req, wdata,
    output gnt, ack, q, owner, busy
  );
endinterface

// File: rtl/dff_rr_write_arbiter.sv
// Round-robin arbiter sharing one W-bit register between N requesters using a
// registered grant -> commit/ack sequence. All outputs come straight from flops.
module dff_rr_write_arbiter #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 8,
  localparam int unsigned IW = $clog2(N)
) (
  input logic                   clk,
  input logic                   reset_n,
  dff_rr_write_arbiter_if.slave bus_io
);

  typedef enum logic [1:0] {StIdle, StGrant, StAck} state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] owner_q, owner_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic [N-1:0]  ack_q, ack_d;
  logic [W-1:0]  q_q, q_d;

  logic [IW-1:0] win_idx;
  logic          win_found;
  logic [W-1:0]  own_wdata;
  logic          own_req;
  logic [IW-1:0] owner_inc;

  // First requester at or after the pointer, wrapping around.
  always_comb begin
    int unsigned cand;
    cand      = 0;
    win_idx   = '0;
    win_found = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = (int'(ptr_q) + k) % N;
      if (!win_found && bus_io.req[cand]) begin
        win_found = 1'b1;
        win_idx   = IW'(cand);
      end
    end
  end

  always_comb begin
    own_wdata = '0;
    own_req   = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (owner_q == IW'(i)) begin
        own_wdata = bus_io.wdata[i*W +: W];
        own_req   = bus_io.req[i];
      end
    end
  end

  assign owner_inc = (owner_q == IW'(N - 1)) ? '0 : owner_q + 1'b1;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    q_d     = q_q;
    gnt_d   = '0;
    ack_d   = '0;
    unique case (state_q)
      StIdle: begin
        if (win_found) begin
          state_d = StGrant;
          gnt_d   = N'(1) << win_idx;
          owner_d = win_idx;
        end
      end
      StGrant: begin
        // Pointer advances past the owner whether it commits or withdraws.
        ptr_d = owner_inc;
        if (own_req) begin
          q_d     = own_wdata;
          ack_d   = gnt_q;
          state_d = StAck;
        end else begin
          state_d = StIdle;
        end
      end
      StAck: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      owner_q <= '0;
      gnt_q   <= '0;
      ack_q   <= '0;
      q_q     <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
      q_q     <= q_d;
    end
  end

  assign bus_io.gnt   = gnt_q;
  assign bus_io.ack   = ack_q;
  assign bus_io.q     = q_q;
  assign bus_io.owner = owner_q;
  assign bus_io.busy  = (state_q != StIdle);

endmodule

// File: doc/dff_rr_write_arbiter.md
Name: dff_rr_write_arbiter

Overview:
Round-robin arbiter and sequencer that shares one W-bit register between N requesters. The register is built from async-reset D flip-flops. The block resolves simultaneous write requests, runs a three-phase grant/commit/acknowledge sequence, and exposes the register contents and current owner. It sits between requesting control blocks and the shared state register.

Parameters:
N, 4, number of requesters (>= 2)
W, 8, width of the shared register and of each write-data slice
IW, $clog2(N), width of owner index (derived; not overridden)

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  asynchronous active-low reset
req  input  N  write request per requester, level, held until ack or voluntarily withdrawn
wdata  input  N*W  write data; slice i = wdata[i*W +: W]
gnt  output  N  one-hot grant, high only in GRANT state
ack  output  N  one-hot, one-cycle commit pulse, high only in ACK state
q  output  W  shared register contents
owner  output  IW  index of the last granted requester
busy  output  1  high when state != IDLE

Behaviour:
- Reset is asynchronous, active-low, and takes effect immediately, independent of clk:
  - state=IDLE, q=0, gnt=0, ack=0, owner=0, busy=0, round-robin pointer ptr=0.
  - Reset asserted mid-sequence aborts the sequence: no write and no ack.
- States: IDLE, GRANT, ACK. All outputs are registered; there are no combinational paths from req to gnt or ack.
- IDLE:
  - If req != 0 at a rising edge, select winner i = first set bit scanning ptr, ptr+1, ..., N-1, 0, ..., ptr-1.
  - Next cycle: gnt[i]=1, owner=i, state=GRANT.
  - If req == 0, stay in IDLE; all outputs hold.
- GRANT (exactly 1 cycle):
  - If req[i] is still 1 at the closing edge: q <= wdata slice i, go to ACK. The next cycle has ack[i]=1 and gnt=0.
  - If req[i] is 0 at the closing edge (withdrawn): abort. q is unchanged, no ack, go to IDLE.
  - Other requesters' req changes in this state are ignored.
- ACK (exactly 1 cycle): ack[i]=1, then go to IDLE.
- Pointer update: ptr <= (i+1) mod N at the GRANT exit edge, on both commit and abort. ptr wraps from N-1 to 0.
- Throughput: one commit per 3 cycles under continuous requests.
  - Request sampled at edge T; gnt at T+1; q updated and ack high at T+2; new arbitration sampled at edge T+3.
- Requesters must drop req during their ACK cycle. If req is still high when IDLE is re-entered, it is treated as a new request under round-robin order. No requester starves: worst-case wait is N-1 sequences.
- gnt and ack are never simultaneously non-zero, and each is never more than one-hot.
- q changes only at a GRANT-exit commit edge or on reset.

Test Plan:
1. reset_n driven low between clock edges during GRANT with q=0x5A → q, gnt, ack, busy, owner all 0 immediately; after release with req=0, stays IDLE with outputs 0.
2. After reset, req=4'b0001, slice0=0xA5 at edge T → gnt=0001 at T+1; q=0xA5 and ack=0001 at T+2; busy=0 at T+3; next grant picks from index 1.
3. req=4'b1111 held, slices 0x11, 0x22, 0x33, 0x44, each req dropped on its ack → grant order 0, 1, 2, 3, one per 3 cycles; q sequence 0x11, 0x22, 0x33, 0x44.
4. Pointer wrap: ptr=2 (after committing requester 1), req=4'b0011 → requester 0 is granted, then requester 1; ptr ends at 2.
5. Withdrawal: req[1] granted, then dropped during GRANT, with q=0x33 → no ack; q stays 0x33; ptr=2; busy=0 the following cycle.
6. Held req: requester 3 keeps req high through ack while req[0] is also high → requester 0 is granted next, then requester 3 again.
